// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default widths, a constant
// clog2 and the two-state holding enum.
package fifo_pkg;

  localparam int DEF_MEMORY_WIDTH = 32;
  localparam int DEF_OUT_WIDTH    = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_read_unpacker.sv
// Pops FIFO words and streams them out as OUT_WIDTH beats, LSB beat first,
// with a last flag on each word's final beat; no bubble across word boundaries.
module fifo_read_unpacker
  import fifo_pkg::*;
#(
  parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH
) (
  input  logic                    r_clk,
  input  logic                    rrst,
  input  logic                    r_empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int RATIO = MEMORY_WIDTH / OUT_WIDTH;
  localparam int BW    = (clog2(RATIO) > 1) ? clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  if ((MEMORY_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $error("fifo_read_unpacker: MEMORY_WIDTH must be a multiple of OUT_WIDTH");
  end

  state_e                  state_q, state_d;
  logic [MEMORY_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]           beat_q, beat_d;

  logic valid_q, accept, at_last, end_word;

  assign valid_q  = (state_q == HOLD);
  assign accept   = valid_q & out_ready;
  assign at_last  = (beat_q == LAST_BEAT);
  assign end_word = accept & at_last;

  // Popping on the final accepted beat reloads the register in the same edge.
  assign r_en = !rrst & !r_empty & (!valid_q | end_word);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    if (r_en) begin
      state_d = HOLD;
      word_d  = rdata;
      beat_d  = '0;
    end else if (end_word) begin
      state_d = EMPTY;
    end else if (accept) begin
      word_d = word_q >> OUT_WIDTH;
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_q <= EMPTY;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

  assign out_data  = word_q[OUT_WIDTH-1:0];
  assign out_valid = valid_q;
  assign out_last  = valid_q & at_last;
  assign busy      = valid_q;

endmodule
